fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch stage with a decoupling instruction queue. It owns the program counter and drives the instruction-memory address. Fetched instruction/PC+4 pairs are buffered in a DEPTH-entry FIFO that the decode stage drains through a valid/ready handshake. Decode sends a redirect for branches and other control transfers; the redirect flushes the queue and reloads the PC. It replaces the single fetch/decode pipeline register, so a decode stall no longer stops instruction fetch until the queue fills.

## Interface
- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_addr  out  32  current PC; instruction-memory read address
- imem_rd  in  32  instruction at imem_addr; combinational, valid in the same cycle
- imem_ready  in  1  imem_rd is valid this cycle
- redirect  in  1  flush the queue and load redirect_pc
- redirect_pc  in  32  redirect target address
- instr_d  out  32  instruction at the queue head
- pcplus4_d  out  32  PC+4 of the head instruction
- predjump_d  out  1  head entry was jump-predecoded (0 when the macro is off)
- valid_d  out  1  head entry valid (queue not empty)
- ready_d  in  1  decode accepts the head this cycle
- count  out  $clog2(DEPTH)+1  occupied entries
- full  out  1  count == DEPTH

## Operation
- Signal definitions:
  - deq = valid_d & ready_d
  - enq = imem_ready & ~redirect & (~full | deq)
- Priority each cycle: reset > redirect > normal operation.
- Reset: PC=RESET_PC, read/write pointers=0, count=0, all entries cleared to 0.
  - Outputs read 0 and valid_d=0.
- Redirect:
  - PC ← redirect_pc, pointers and count ← 0.
  - No enqueue that cycle.
  - A deq asserted in the same cycle is treated as consumed and does not affect the flush.
- Normal operation:
  - On enq, write {imem_rd, PC+4, pj} at wptr, advance wptr, and set PC ← next_pc.
  - On deq, advance rptr.
  - count += enq − deq.
  - When enq and deq coincide, count is unchanged. This includes enq while full, which is allowed only together with deq.
- next_pc:
  - PC+4, or the predecoded jump target (see Configuration).
  - Arithmetic is modulo 2^32; PC 32'hFFFF_FFFC wraps to 0.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- Head outputs are a combinational read of the entry at rptr. They hold stable while valid_d & ~ready_d.
- When imem_ready=0, the PC holds and no entry is written.
- full and count are derived from registered state only. They do not depend on same-cycle enq/deq.

## Timing
- Fetch latency: an instruction sampled at edge t appears at the head in cycle t+1 when the queue was empty. There is no combinational imem→decode path.
- Redirect asserted in cycle t:
  - valid_d=0 in cycle t+1.
  - imem_addr=redirect_pc in t+1.
  - The target instruction is at the head in t+2, given imem_ready.
- Throughput: one enqueue and one dequeue per cycle sustained.
- Reset asserted mid-operation overrides redirect/enq/deq in that cycle. State equals the reset values after the edge.

## Configuration
- FETCHQ_JUMP_PREDECODE_EN
  - Defined: on enq, if imem_rd[31:26] is 6'b000010 (j) or 6'b000011 (jal):
    - next_pc = {PC+4[31:28], imem_rd[25:0], 2'b00}.
    - The entry's pj=1, so predjump_d=1 at the head.
    - Decode must not redirect for a pj=1 jump.
  - Undefined: next_pc is always PC+4, pj=0, and predjump_d is tied 0. Jumps resolve through redirect.

## Test plan
- Reset then fill: hold reset 2 cycles, then release with imem_ready=1, ready_d=0, DEPTH=4. Required response:
  - imem_addr steps 0,4,8,12.
  - full=1 after 4 edges; PC holds at 16.
  - count=4; head instr = word at 0, pcplus4_d=4.
- Simultaneous enq/deq at full: with the queue full, set ready_d=1 for 3 cycles. Required response:
  - count stays 4.
  - Heads 0,4,8 are dequeued while 16,20,24 are fetched.
- Redirect while non-empty: count=3, pulse redirect with redirect_pc=32'h100 and ready_d=1. Required response:
  - Next cycle valid_d=0, count=0, imem_addr=0x100.
  - One cycle later head pcplus4_d=0x104.
- Memory wait: deassert imem_ready for 3 cycles. Required response:
  - imem_addr frozen, no enq, count only decrements on deq.
  - Fetch resumes at the same PC.
- Jump predecode (macro on): word at 0x40 is 32'h0800_0020. Required response:
  - After enqueue, imem_addr=0x80 and predjump_d=1 at the head.
  - With the macro off, imem_addr=0x44 and predjump_d=0.
- Wrap and reset mid-run: set PC to 32'hFFFF_FFFC via redirect; next fetch address must be 0. Then assert reset during enq+deq. Required response:
  - count=0, valid_d=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage owning the PC, feeding decode through a DEPTH-entry queue
// Optional jump predecode is enabled by defining FETCHQ_JUMP_PREDECODE_EN.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rd,
    input  logic                     imem_ready,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [31:0]              instr_d,
    output logic [31:0]              pcplus4_d,
    output logic                     predjump_d,
    output logic                     valid_d,
    input  logic                     ready_d,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc4_q   [DEPTH];
    logic [31:0]   pc_q, pc_d, pc_plus4, next_pc;
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          enq, deq, pj;

    assign pc_plus4  = pc_q + 32'd4;
    assign imem_addr = pc_q;
    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign valid_d   = (count_q != '0);
    assign instr_d   = instr_q[rptr_q];
    assign pcplus4_d = pc4_q[rptr_q];

    assign deq = valid_d & ready_d;
    assign enq = imem_ready & ~redirect & (~full | deq);

`ifdef FETCHQ_JUMP_PREDECODE_EN
    logic pj_q [DEPTH];

    // j (000010) and jal (000011) differ only in bit 26.
    assign pj         = (imem_rd[31:27] == 5'b00001);
    assign next_pc    = pj ? {pc_plus4[31:28], imem_rd[25:0], 2'b00} : pc_plus4;
    assign predjump_d = pj_q[rptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pj_q[i] <= 1'b0;
            end
        end else if (enq) begin
            pj_q[wptr_q] <= pj;
        end
    end
`else
    assign pj         = 1'b0;
    assign next_pc    = pc_plus4;
    assign predjump_d = pj;
`endif

    always_comb begin
        pc_d    = pc_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (redirect) begin
            // A same-cycle dequeue is simply lost in the flush.
            pc_d    = redirect_pc;
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                pc_d   = next_pc;
                wptr_d = wptr_q + PW'(1);
            end
            if (deq) begin
                rptr_d = rptr_q + PW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc4_q[i]   <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            if (enq) begin
                instr_q[wptr_q] <= imem_rd;
                pc4_q[wptr_q]   <= pc_plus4;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue against a queue-based reference model
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, imem_ready, redirect, ready_d;
    logic [31:0] imem_addr, imem_rd, redirect_pc, instr_d, pcplus4_d;
    logic        predjump_d, valid_d, full;
    logic [$clog2(DEPTH):0] count;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .imem_ready(imem_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_d(instr_d), .pcplus4_d(pcplus4_d), .predjump_d(predjump_d),
        .valid_d(valid_d), .ready_d(ready_d), .count(count), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        pj;
    } ent_t;

    ent_t        sb[$];
    logic [31:0] m_pc;
    int          n_checks = 0;
    int          n_pass   = 0;

    // Opcode bits forced >= 6'b100000 so only the planted word at 0x40 is a jump.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'h40) return 32'h0800_0020;
        h = (a ^ 32'hA5C3_0F1E) * 32'h0001_0003 + 32'h1357_9BDF;
        h[31] = 1'b1;
        return h;
    endfunction

    function automatic logic is_jump(input logic [31:0] w);
`ifdef FETCHQ_JUMP_PREDECODE_EN
        return (w[31:26] == 6'd2) || (w[31:26] == 6'd3);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        if (is_jump(w)) return {p4[31:28], w[25:0], 2'b00};
        return p4;
    endfunction

    always_comb imem_rd = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every accepted head is compared with the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && valid_d === 1'b1 && ready_d === 1'b1) begin
            if (sb.size() == 0) begin
                chk("head_unexpected", 32'd1, 32'd0);
            end else begin
                chk("head_instr", instr_d, sb[0].instr);
                chk("head_pcplus4", pcplus4_d, sb[0].pc4);
                chk("head_predjump", {31'd0, predjump_d}, {31'd0, sb[0].pj});
                void'(sb.pop_front());
            end
        end
    end

    // One clock: entered and left at posedge+1.
    task automatic cycle(input logic ir, input logic rd, input logic rdr, input logic [31:0] rpc);
        logic e_deq, e_enq;
        ent_t e;
        imem_ready = ir; ready_d = rd; redirect = rdr; redirect_pc = rpc;
        #1;
        chk("imem_addr", imem_addr, m_pc);
        chk("count", {28'd0, count}, sb.size());
        chk("valid_d", {31'd0, valid_d}, {31'd0, sb.size() != 0});
        chk("full", {31'd0, full}, {31'd0, sb.size() == DEPTH});
        e_deq   = (sb.size() != 0) && rd;
        e_enq   = ir && !rdr && ((sb.size() < DEPTH) || e_deq);
        e.instr = mem_word(m_pc);
        e.pc4   = m_pc + 32'd4;
        e.pj    = is_jump(e.instr);
        @(negedge clk); #1;
        if (rdr) begin
            sb.delete();
            m_pc = rpc;
        end else if (e_enq) begin
            sb.push_back(e);
            m_pc = model_next(m_pc, e.instr);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n, input logic ir, input logic rd);
        reset = 1'b1; imem_ready = ir; ready_d = rd; redirect = 1'b0;
        repeat (n) begin
            @(negedge clk); #1;
            @(posedge clk); #1;
        end
        reset = 1'b0;
        sb.delete();
        m_pc = RESET_PC;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] saved, r;
        reset = 1'b1; imem_ready = 1'b0; ready_d = 1'b0; redirect = 1'b0; redirect_pc = '0;
        m_pc = RESET_PC;
        @(posedge clk); #1;

        do_reset(2, 1'b1, 1'b0);
        #1;
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_valid", {31'd0, valid_d}, 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_instr", instr_d, 32'd0);
        chk("rst_pc4", pcplus4_d, 32'd0);
        chk("rst_pj", {31'd0, predjump_d}, 32'd0);

        repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_count", {28'd0, count}, 32'd4);
        chk("fill_addr", imem_addr, 32'd16);
        chk("fill_head", instr_d, mem_word(32'd0));
        chk("fill_pc4", pcplus4_d, 32'd4);
        cycle(1'b1, 1'b0, 1'b0, 32'd0);

        repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("full_enqdeq_count", {28'd0, count}, 32'd4);
        chk("full_enqdeq_addr", imem_addr, 32'd28);

        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 32'h100);
        chk("redir_valid", {31'd0, valid_d}, 32'd0);
        chk("redir_count", {28'd0, count}, 32'd0);
        chk("redir_addr", imem_addr, 32'h100);
        cycle(1'b1, 1'b0, 1'b0, 32'd0);
        chk("redir_pc4", pcplus4_d, 32'h104);

        repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        saved = imem_addr;
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        chk("wait_addr", imem_addr, saved);
        chk("wait_count", {28'd0, count}, 32'd1);
        cycle(1'b1, 1'b0, 1'b0, 32'd0);

        cycle(1'b1, 1'b0, 1'b1, 32'h40);
        cycle(1'b1, 1'b0, 1'b0, 32'd0);
        chk("jump_head", instr_d, 32'h0800_0020);
`ifdef FETCHQ_JUMP_PREDECODE_EN
        chk("jump_addr", imem_addr, 32'h80);
        chk("jump_pj", {31'd0, predjump_d}, 32'd1);
`else
        chk("jump_addr", imem_addr, 32'h44);
        chk("jump_pj", {31'd0, predjump_d}, 32'd0);
`endif

        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 1'b0, 32'd0);
        chk("wrap_addr", imem_addr, 32'd0);
        chk("wrap_pc4", pcplus4_d, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0);
        do_reset(1, 1'b1, 1'b1);
        #1;
        chk("midrst_count", {28'd0, count}, 32'd0);
        chk("midrst_valid", {31'd0, valid_d}, 32'd0);
        chk("midrst_addr", imem_addr, RESET_PC);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom;
            r[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) r = 32'h40;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
